// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: register-file bus width, starvation counter width, FIFO entry type and dest decode
package rf_wport_arbiter_pkg;
  localparam int Wrf_BUS_Wid = 38;
  localparam int RFARB_STARVE_W = 4;
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } rf_entry_t;
  function automatic logic [31:0] dest_onehot(input logic [4:0] d);
    return 32'd1 << d;
  endfunction
endpackage

// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if: Writeback request (W_*), secondary push (lu_*), hazard mask and register-file write bus
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;
  logic                   W_we;
  logic [4:0]             W_dest;
  logic [31:0]            W_data;
  logic                   W_hold;
  logic                   lu_valid;
  logic [4:0]             lu_dest;
  logic [31:0]            lu_data;
  logic                   lu_ready;
  logic [31:0]            pend_mask;
  logic [Wrf_BUS_Wid-1:0] Wrf_BUS;
  modport master (
    output W_we, W_dest, W_data, lu_valid, lu_dest, lu_data,
    input  W_hold, lu_ready, pend_mask, Wrf_BUS
  );
  modport slave (
    input  W_we, W_dest, W_data, lu_valid, lu_dest, lu_data,
    output W_hold, lu_ready, pend_mask, Wrf_BUS
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry {dest,data} FIFO; push_i/pop_i/din_i in, head_o/count_o/vld_o/dest_o (per-entry) out
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  rf_entry_t             din_i,
  output rf_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [DEPTH-1:0]      vld_o,
  output logic [DEPTH-1:0][4:0] dest_o
);
  rf_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_i);
      rptr_q  <= rptr_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
      vld_q   <= (vld_q & ~(DEPTH'(pop_i) << rptr_q)) | (DEPTH'(push_i) << wptr_q);
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_dest
    assign dest_o[i] = mem_q[i].dest;
  end
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign vld_o   = vld_q;
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the RF write port between Writeback and a buffered secondary requester; clk/rstn + bus (slave)
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rstn,
  rf_wport_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  rf_entry_t                 head;
  logic [CW-1:0]             count;
  logic [DEPTH-1:0]          vld;
  logic [DEPTH-1:0][4:0]     dest;
  logic [RFARB_STARVE_W-1:0] starve_q, starve_d;
  logic                      nonempty, push, hold, w_grant, head_grant;
  logic [31:0]               mask;
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (head_grant),
    .din_i   ({bus.lu_dest, bus.lu_data}),
    .head_o  (head),
    .count_o (count),
    .vld_o   (vld),
    .dest_o  (dest)
  );
  assign nonempty     = count != '0;
  assign bus.lu_ready = rstn && count != CW'(DEPTH);
  assign push         = bus.lu_valid && bus.lu_ready && bus.lu_dest != '0;
  assign hold         = rstn && nonempty && starve_q == RFARB_STARVE_W'(STARVE_MAX);
  assign w_grant      = rstn && !hold && bus.W_we && bus.W_dest != '0;
  assign head_grant   = rstn && nonempty && !w_grant;
  assign bus.W_hold   = hold;
  // a non-empty FIFO at STARVE_MAX always wins next, so the increment never overruns
  assign starve_d     = (!nonempty || head_grant) ? '0 : starve_q + 1'b1;
  assign bus.Wrf_BUS  = w_grant ? {1'b1, bus.W_dest, bus.W_data} :
                        head_grant ? {1'b1, head.dest, head.data} : '0;
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) mask |= vld[i] ? dest_onehot(dest[i]) : '0;
  end
  assign bus.pend_mask = rstn ? (mask & ~32'd1) : '0;
  always_ff @(posedge clk) begin
    if (!rstn) starve_q <= '0;
    else starve_q <= starve_d;
  end
endmodule
